// File: rtl/mips_mem_arbiter_if.sv
// Purpose: CPU-side request/response and Avalon-style memory bus signals of the arbiter.
// Latency: none, wires only.
// Backpressure: waitrequest from the memory slave stalls the granted requester.
interface mips_mem_arbiter_if;
  // instruction fetch requester
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_valid;
  logic [31:0] if_rdata;
  // data (lw/sw) requester
  logic        d_req;
  logic        d_write;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_byteenable;
  logic        d_valid;
  logic [31:0] d_rdata;
  logic        bus_timeout;
  // memory bus
  logic [31:0] address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic [31:0] readdata;
  logic        waitrequest;

  // arbiter view: takes requests and bus responses, drives the bus and completions
  modport slave (
    input  if_req, if_addr, d_req, d_write, d_addr, d_wdata, d_byteenable,
    input  readdata, waitrequest,
    output if_valid, if_rdata, d_valid, d_rdata, bus_timeout,
    output address, read, write, writedata, byteenable
  );

  // environment view: CPU requesters plus the memory slave
  modport master (
    output if_req, if_addr, d_req, d_write, d_addr, d_wdata, d_byteenable,
    output readdata, waitrequest,
    input  if_valid, if_rdata, d_valid, d_rdata, bus_timeout,
    input  address, read, write, writedata, byteenable
  );
endinterface

// File: rtl/mips_mem_arbiter.sv
// Purpose: round-robin share of one memory bus between instruction fetch and data access.
// Latency: grant edge N, strobe N..N+1, valid N+1..N+2 with zero wait states; grants 3 cycles apart.
// Backpressure: waitrequest holds the bus cycle; a stall of TIMEOUT cycles aborts it and sets bus_timeout.
module mips_mem_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_enable,
  mips_mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;
  typedef enum logic {G_IF = 1'b0, G_DATA = 1'b1} grant_e;

  localparam logic [15:0] TIMEOUT_C = 16'(TIMEOUT);

  state_e      state_q, state_d;
  // last_grant also names the owner of the transaction in BUSY/DONE
  grant_e      last_grant_q, last_grant_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] cnt_inc;
  logic [31:0] address_q, address_d;
  logic        read_q, read_d;
  logic        write_q, write_d;
  logic [31:0] writedata_q, writedata_d;
  logic [3:0]  byteenable_q, byteenable_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic        if_valid_q, if_valid_d;
  logic        d_valid_q, d_valid_d;
  logic        timeout_q, timeout_d;

  assign cnt_inc = cnt_q + 16'd1;

  // Next-state: arbitration in IDLE, bus completion/abort in BUSY, single valid cycle in DONE.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    address_d    = address_q;
    read_d       = read_q;
    write_d      = write_q;
    writedata_d  = writedata_q;
    byteenable_d = byteenable_q;
    if_rdata_d   = if_rdata_q;
    d_rdata_d    = d_rdata_q;
    if_valid_d   = 1'b0;
    d_valid_d    = 1'b0;
    timeout_d    = timeout_q;

    case (state_q)
      S_IDLE: begin
        if (bus.if_req || bus.d_req) begin
          cnt_d   = 16'd0;
          state_d = S_BUSY;
          // fetch wins when alone or when data had the previous grant
          if (bus.if_req && (!bus.d_req || last_grant_q == G_DATA)) begin
            last_grant_d = G_IF;
            address_d    = bus.if_addr;
            read_d       = 1'b1;
            write_d      = 1'b0;
            writedata_d  = 32'd0;
            byteenable_d = 4'hF;
          end else begin
            last_grant_d = G_DATA;
            address_d    = bus.d_addr;
            read_d       = ~bus.d_write;
            write_d      = bus.d_write;
            writedata_d  = bus.d_wdata;
            byteenable_d = bus.d_byteenable;
          end
        end
      end

      S_BUSY: begin
        if (!bus.waitrequest) begin
          if (read_q) begin
            if (last_grant_q == G_IF) if_rdata_d = bus.readdata;
            else                      d_rdata_d  = bus.readdata;
          end
          read_d     = 1'b0;
          write_d    = 1'b0;
          if_valid_d = (last_grant_q == G_IF);
          d_valid_d  = (last_grant_q == G_DATA);
          state_d    = S_DONE;
        end else if (cnt_inc == TIMEOUT_C) begin
          // abandon the stalled cycle; requester still gets its completion pulse
          read_d     = 1'b0;
          write_d    = 1'b0;
          timeout_d  = 1'b1;
          if_valid_d = (last_grant_q == G_IF);
          d_valid_d  = (last_grant_q == G_DATA);
          state_d    = S_DONE;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register: synchronous active-low reset, clk_enable freezes everything.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      last_grant_q <= G_DATA;
      cnt_q        <= 16'd0;
      address_q    <= 32'd0;
      read_q       <= 1'b0;
      write_q      <= 1'b0;
      writedata_q  <= 32'd0;
      byteenable_q <= 4'd0;
      if_rdata_q   <= 32'd0;
      d_rdata_q    <= 32'd0;
      if_valid_q   <= 1'b0;
      d_valid_q    <= 1'b0;
      timeout_q    <= 1'b0;
    end else if (clk_enable) begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      address_q    <= address_d;
      read_q       <= read_d;
      write_q      <= write_d;
      writedata_q  <= writedata_d;
      byteenable_q <= byteenable_d;
      if_rdata_q   <= if_rdata_d;
      d_rdata_q    <= d_rdata_d;
      if_valid_q   <= if_valid_d;
      d_valid_q    <= d_valid_d;
      timeout_q    <= timeout_d;
    end
  end

  assign bus.address     = address_q;
  assign bus.read        = read_q;
  assign bus.write       = write_q;
  assign bus.writedata   = writedata_q;
  assign bus.byteenable  = byteenable_q;
  assign bus.if_rdata    = if_rdata_q;
  assign bus.d_rdata     = d_rdata_q;
  assign bus.if_valid    = if_valid_q;
  assign bus.d_valid     = d_valid_q;
  assign bus.bus_timeout = timeout_q;

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Purpose: randomized scoreboard bench for mips_mem_arbiter with a transaction-level model.
// Latency: checks grant-to-valid spacing and strobe lengths on directed cases.
// Backpressure: memory slave model inserts per-transaction wait states, including timeouts.
module tb_mips_mem_arbiter;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic reset;
  logic clk_enable;
  logic ce_at_edge = 1'b1;
  int   cycle = 0;

  mips_mem_arbiter_if bus_if();

  mips_mem_arbiter #(.TIMEOUT(TO)) dut (
    .clk        (clk),
    .reset      (reset),
    .clk_enable (clk_enable),
    .bus        (bus_if.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    ce_at_edge <= clk_enable;
    cycle      <= cycle + 1;
  end

  typedef struct packed {
    logic [31:0] addr;
    logic        rd;
    logic        wr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } bus_t;

  typedef struct packed {
    logic        is_if;
    logic [31:0] rdata;
    logic [31:0] other;
    logic        tmo;
  } resp_t;

  bus_t  exp_bus[$];
  resp_t exp_resp[$];
  int    stall_q[$];
  int    valid_cycs[$];
  int    grant_cyc = 0, valid_cyc = 0, strobe_len = 0;

  int vectors = 0;
  int errors  = 0;

  // transaction-level reference state
  bit          last_was_data = 1'b1;
  logic [31:0] m_if_rdata = '0, m_d_rdata = '0;
  bit          m_tmo = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'hBFC0_0000) return 32'h2402_0005;
    return {a[15:0], a[31:16]} ^ 32'hC3A5_1E0F;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Queue the expected bus cycle, wait states and completion of one transaction.
  task automatic model_txn(input bit is_if, input logic [31:0] addr, input bit wr,
                           input logic [31:0] wdata, input logic [3:0] be, input int stall);
    bus_t  b;
    resp_t r;
    bit    tmo;
    tmo     = (stall >= TO);
    b.addr  = addr;
    b.rd    = is_if ? 1'b1 : !wr;
    b.wr    = is_if ? 1'b0 : wr;
    b.wdata = is_if ? 32'd0 : wdata;
    b.be    = is_if ? 4'hF : be;
    if (tmo) m_tmo = 1'b1;
    if (!tmo && b.rd) begin
      if (is_if) m_if_rdata = mem_word(addr);
      else       m_d_rdata  = mem_word(addr);
    end
    r.is_if = is_if;
    r.rdata = is_if ? m_if_rdata : m_d_rdata;
    r.other = is_if ? m_d_rdata : m_if_rdata;
    r.tmo   = m_tmo;
    last_was_data = !is_if;
    exp_bus.push_back(b);
    exp_resp.push_back(r);
    stall_q.push_back(stall);
  endtask

  // mode 0: clk_enable always 1; mode 1: random gaps; mode 2: 5 disabled cycles once the strobe rises
  task automatic run_round(input bit want_if, input bit want_d, input logic [31:0] fa,
                           input logic [31:0] da, input bit dw, input logic [31:0] dwd,
                           input logic [3:0] dbe, input int st_if, input int st_d, input int mode);
    int cyc, gap;
    bit ip, dp;
    if (want_if && want_d) begin
      if (last_was_data) begin
        model_txn(1'b1, fa, 1'b0, 32'd0, 4'd0, st_if);
        model_txn(1'b0, da, dw, dwd, dbe, st_d);
      end else begin
        model_txn(1'b0, da, dw, dwd, dbe, st_d);
        model_txn(1'b1, fa, 1'b0, 32'd0, 4'd0, st_if);
      end
    end else if (want_if) model_txn(1'b1, fa, 1'b0, 32'd0, 4'd0, st_if);
    else if (want_d)      model_txn(1'b0, da, dw, dwd, dbe, st_d);
    ip = want_if; dp = want_d; cyc = 0; gap = -1;
    clk_enable          = 1'b1;
    bus_if.if_req       = want_if;
    bus_if.if_addr      = fa;
    bus_if.d_req        = want_d;
    bus_if.d_addr       = da;
    bus_if.d_write      = dw;
    bus_if.d_wdata      = dwd;
    bus_if.d_byteenable = dbe;
    while ((ip || dp) && cyc < 300) begin
      @(posedge clk); #2;
      cyc++;
      if (bus_if.if_valid && ip) begin ip = 1'b0; bus_if.if_req = 1'b0; end
      if (bus_if.d_valid && dp)  begin dp = 1'b0; bus_if.d_req  = 1'b0; end
      // the granted request is already latched: disturbing it must not matter
      if ((bus_if.read || bus_if.write) && (ip ^ dp)) begin
        if (ip) bus_if.if_addr = $urandom;
        else begin
          bus_if.d_addr       = $urandom;
          bus_if.d_wdata      = $urandom;
          bus_if.d_write      = 1'($urandom_range(0, 1));
          bus_if.d_byteenable = 4'($urandom_range(0, 15));
        end
      end
      if (mode == 1) clk_enable = ($urandom_range(0, 99) >= 15);
      else if (mode == 2) begin
        if (gap < 0 && (bus_if.read || bus_if.write)) gap = 5;
        clk_enable = !(gap > 0);
        if (gap > 0) gap--;
      end
    end
    clk_enable = 1'b1;
    check("round_complete", 32'(ip || dp), 32'd0);
  endtask

  task automatic settle();
    repeat (2) @(negedge clk);
    #1;
  endtask

  // Memory slave: pops the wait-state count at each new bus cycle, counts only enabled edges.
  initial begin
    int  remaining;
    bit  active;
    remaining = 0;
    active    = 1'b0;
    bus_if.waitrequest = 1'b0;
    bus_if.readdata    = '0;
    forever begin
      @(posedge clk); #1;
      if (bus_if.read || bus_if.write) begin
        if (!active) begin
          active    = 1'b1;
          remaining = (stall_q.size() > 0) ? stall_q.pop_front() : 0;
        end else if (ce_at_edge && remaining > 0) remaining--;
        bus_if.waitrequest = (remaining > 0);
        bus_if.readdata    = (remaining > 0) ? $urandom : mem_word(bus_if.address);
      end else begin
        active             = 1'b0;
        bus_if.waitrequest = 1'($urandom_range(0, 1));
        bus_if.readdata    = $urandom;
      end
    end
  end

  // Monitor: compares every new bus cycle and every completion pulse against the queues.
  initial begin
    bit   strobe, strobe_prev, vld, vld_prev;
    bus_t cur, obs;
    resp_t r;
    int   len;
    strobe_prev = 1'b0; vld_prev = 1'b0; len = 0; cur = '0;
    forever begin
      @(negedge clk);
      strobe = (bus_if.read === 1'b1) || (bus_if.write === 1'b1);
      vld    = (bus_if.if_valid === 1'b1) || (bus_if.d_valid === 1'b1);
      obs    = {bus_if.address, bus_if.read, bus_if.write, bus_if.writedata, bus_if.byteenable};
      if (strobe) check("strobe_excl", 32'(bus_if.read & bus_if.write), 32'd0);
      if (vld)    check("valid_excl", 32'(bus_if.if_valid & bus_if.d_valid), 32'd0);
      if (strobe && !strobe_prev) begin
        grant_cyc = cycle;
        len = 1;
        if (exp_bus.size() == 0) begin
          check("unexpected_bus_cycle", obs.addr, 32'hFFFF_FFFF);
          cur = obs;
        end else begin
          cur = exp_bus.pop_front();
          check("bus_address", obs.addr, cur.addr);
          check("bus_strobes", {30'd0, obs.rd, obs.wr}, {30'd0, cur.rd, cur.wr});
          check("bus_writedata", obs.wdata, cur.wdata);
          check("bus_byteenable", 32'(obs.be), 32'(cur.be));
        end
      end else if (strobe) begin
        len++;
        check("bus_hold_address", obs.addr, cur.addr);
        check("bus_hold_ctl", {26'd0, obs.rd, obs.wr, obs.be}, {26'd0, cur.rd, cur.wr, cur.be});
        check("bus_hold_writedata", obs.wdata, cur.wdata);
      end else if (strobe_prev) strobe_len = len;
      if (vld && (!vld_prev || ce_at_edge)) begin
        valid_cyc = cycle;
        valid_cycs.push_back(cycle);
        if (exp_resp.size() == 0) check("unexpected_valid", 32'(vld), 32'd0);
        else begin
          r = exp_resp.pop_front();
          check("resp_port_is_fetch", 32'(bus_if.if_valid), 32'(r.is_if));
          check("resp_rdata", r.is_if ? bus_if.if_rdata : bus_if.d_rdata, r.rdata);
          check("resp_other_rdata", r.is_if ? bus_if.d_rdata : bus_if.if_rdata, r.other);
          check("resp_bus_timeout", 32'(bus_if.bus_timeout), 32'(r.tmo));
        end
      end
      strobe_prev = strobe;
      vld_prev    = vld;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cycle);
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    bit wi, wd;
    reset = 1'b0; clk_enable = 1'b1;
    bus_if.if_req = 1'b1; bus_if.d_req = 1'b1; bus_if.if_addr = 32'h1234_5678;
    bus_if.d_addr = 32'h0; bus_if.d_write = 1'b0; bus_if.d_wdata = '0; bus_if.d_byteenable = 4'hF;

    // reset held with both requests pending
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_address", bus_if.address, 32'd0);
    check("rst_strobes", {30'd0, bus_if.read, bus_if.write}, 32'd0);
    check("rst_writedata", bus_if.writedata, 32'd0);
    check("rst_byteenable", 32'(bus_if.byteenable), 32'd0);
    check("rst_if_rdata", bus_if.if_rdata, 32'd0);
    check("rst_d_rdata", bus_if.d_rdata, 32'd0);
    check("rst_valids", {30'd0, bus_if.if_valid, bus_if.d_valid}, 32'd0);
    check("rst_timeout", 32'(bus_if.bus_timeout), 32'd0);
    @(posedge clk); #2;
    reset = 1'b1;
    // first grant after reset goes to fetch
    run_round(1, 1, 32'h0000_0100, 32'h0000_0200, 0, 32'd0, 4'hF, 0, 0, 0);
    settle();

    // zero-wait fetch: one strobe cycle, valid the next cycle
    run_round(1, 0, 32'hBFC0_0000, 32'd0, 0, 32'd0, 4'd0, 0, 0, 0);
    settle();
    check("fetch_strobe_len", 32'(strobe_len), 32'd1);
    check("fetch_latency", 32'(valid_cyc - grant_cyc), 32'd1);

    // store with three wait states
    run_round(0, 1, 32'd0, 32'h0000_1000, 1, 32'hDEAD_BEEF, 4'h3, 0, 3, 0);
    settle();
    check("store_strobe_len", 32'(strobe_len), 32'd4);
    check("store_latency", 32'(valid_cyc - grant_cyc), 32'd4);

    // both requesters held: alternate grants, completions 3 cycles apart
    base = valid_cycs.size();
    run_round(1, 1, 32'h0000_0400, 32'h0000_0800, 0, 32'd0, 4'hF, 0, 0, 0);
    run_round(1, 1, 32'h0000_0404, 32'h0000_0804, 1, 32'hCAFE_F00D, 4'hC, 0, 0, 0);
    settle();
    check("rr_completions", 32'(valid_cycs.size() - base), 32'd4);
    if (valid_cycs.size() >= base + 4)
      for (int i = 1; i < 4; i++)
        check("rr_spacing", 32'(valid_cycs[base+i] - valid_cycs[base+i-1]), 32'd3);

    // clock enable dropped for 5 cycles while the fetch is on the bus
    run_round(1, 0, 32'h0040_0000, 32'd0, 0, 32'd0, 4'd0, 0, 0, 2);
    settle();
    check("ce_strobe_len", 32'(strobe_len), 32'd6);

    // load stuck in waitrequest: abort after TO stalled cycles
    run_round(0, 1, 32'd0, 32'h0000_2000, 0, 32'd0, 4'hF, 0, 10, 0);
    settle();
    check("tmo_strobe_len", 32'(strobe_len), 32'(TO));
    check("tmo_sticky", 32'(bus_if.bus_timeout), 32'd1);

    // reset in the middle of a stalled fetch abandons it
    exp_bus.push_back({32'h0000_4000, 1'b1, 1'b0, 32'd0, 4'hF});
    stall_q.push_back(20);
    bus_if.if_addr = 32'h0000_4000; bus_if.if_req = 1'b1; bus_if.d_req = 1'b0;
    for (int k = 0; k < 10 && !bus_if.read; k++) begin @(posedge clk); #2; end
    check("midrst_started", 32'(bus_if.read), 32'd1);
    @(posedge clk); #2;
    reset = 1'b0; bus_if.if_req = 1'b0;
    @(posedge clk); #2;
    check("midrst_strobes", {30'd0, bus_if.read, bus_if.write}, 32'd0);
    check("midrst_timeout_clr", 32'(bus_if.bus_timeout), 32'd0);
    check("midrst_if_rdata", bus_if.if_rdata, 32'd0);
    reset = 1'b1;
    last_was_data = 1'b1; m_if_rdata = '0; m_d_rdata = '0; m_tmo = 1'b0;
    repeat (6) @(posedge clk);
    #2;

    // randomized traffic with random wait states, timeouts and enable gaps
    for (int n = 0; n < 120; n++) begin
      wi = 1'($urandom_range(0, 1));
      wd = 1'($urandom_range(0, 1));
      if (!wi && !wd) wi = 1'b1;
      run_round(wi, wd, $urandom, $urandom, 1'($urandom_range(0, 1)), $urandom,
                4'($urandom_range(1, 15)),
                ($urandom_range(0, 11) == 0) ? $urandom_range(TO, TO + 2) : $urandom_range(0, 3),
                ($urandom_range(0, 11) == 0) ? $urandom_range(TO, TO + 2) : $urandom_range(0, 3),
                ($urandom_range(0, 2) == 0) ? 1 : 0);
    end
    settle();
    check("drain_bus_queue", 32'(exp_bus.size()), 32'd0);
    check("drain_resp_queue", 32'(exp_resp.size()), 32'd0);
    check("drain_stall_queue", 32'(stall_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
